// File: rtl/data_mem_responder.sv
// Single-port word memory behind valid/ready request and response channels.
// One transaction in flight; each access waits LATENCY extra cycles before it touches the array.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [31:0] mem [DEPTH];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        busy_q, busy_d;

    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic          do_access;
    logic          mem_we;

    always_comb begin
        // Full-width compare so high address bits cannot alias into the array.
        in_range  = (addr_q < 32'(DEPTH));
        mem_idx   = addr_q[AW-1:0];
        do_access = (state_q == WAIT) && (cnt_q == 4'd0);
        mem_we    = do_access && we_q && in_range;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = 4'(LATENCY);
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    if (!in_range) begin
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b1;
                    end else if (we_q) begin
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b0;
                    end else begin
                        resp_rdata_d = mem[mem_idx];
                        resp_err_d   = 1'b0;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    // Storage is not reset; an asynchronous reset drops state_q to IDLE, which blocks the commit.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with LATENCY=0 and one with LATENCY=2,
// expected responses queued at request time and compared when each response appears.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    int   last_acc = 0;
    int   last_hs = 0;
    logic pulse_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;
    always @(posedge clk) if (resp_valid[1] === 1'b1) pulse_seen <= 1'b1;

    data_mem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input int s, input string tag);
        chk({tag, " req_ready"}, 32'(req_ready[s]), 32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid[s]), 32'd0);
        chk({tag, " resp_rdata"}, resp_rdata[s], 32'd0);
        chk({tag, " resp_err"}, 32'(resp_err[s]), 32'd0);
        chk({tag, " busy"}, 32'(busy[s]), 32'd0);
    endtask

    // One full transaction; hold > 0 keeps resp_ready low that many cycles while a rogue
    // request (write 0 to addr 5) is presented and must not be accepted.
    task automatic txn(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold, input string tag);
        exp_t e;
        logic acc;
        logic rdy;
        int   cyc;
        int   lat;
        lat = (s == 0) ? 1 : 3;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        resp_ready[s] = (hold > 0) ? 1'b0 : 1'b1;
        req_valid[s]  = 1'b1;
        req_we[s]     = we;
        req_addr[s]   = addr;
        req_wdata[s]  = wdata;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy = req_ready[s];
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        last_acc = ecnt;
        req_valid[s] = 1'b0;
        chk({tag, " accept"}, 32'(acc), 32'd1);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid[s] === 1'b1) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        e = sb.pop_front();
        chk({tag, " rdata"}, resp_rdata[s], e.rdata);
        chk({tag, " err"}, 32'(resp_err[s]), 32'(e.err));
        if (hold > 0) begin
            req_valid[s] = 1'b1;
            req_we[s]    = 1'b1;
            req_addr[s]  = 32'd5;
            req_wdata[s] = 32'd0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk({tag, " hold valid"}, 32'(resp_valid[s]), 32'd1);
                chk({tag, " hold rdata"}, resp_rdata[s], e.rdata);
                chk({tag, " hold req_ready"}, 32'(req_ready[s]), 32'd0);
            end
            resp_ready[s] = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        last_hs = ecnt;
        chk({tag, " hs valid"}, 32'(resp_valid[s]), 32'd0);
        chk({tag, " hs req_ready"}, 32'(req_ready[s]), 32'd1);
        chk({tag, " hs busy"}, 32'(busy[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int prev_hs;
        for (int s = 0; s < 2; s++) begin
            req_valid[s]  = 1'b0;
            req_we[s]     = 1'b0;
            req_addr[s]   = 32'd0;
            req_wdata[s]  = 32'd0;
            resp_ready[s] = 1'b0;
        end

        // Reset asserted mid-cycle, outputs clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk_idle_zero(0, "rst0");
        chk_idle_zero(1, "rst2");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst req_ready low", 32'(req_ready[1]), 32'd0);
        @(posedge clk);
        #1;
        chk("first edge req_ready0", 32'(req_ready[0]), 32'd1);
        chk("first edge req_ready2", 32'(req_ready[1]), 32'd1);
        chk("first edge busy2", 32'(busy[1]), 32'd0);

        txn(1, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 0, "L2 wr5");
        txn(1, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 0, "L2 rd5");

        txn(0, 1'b1, 32'd0, 32'h11, 32'd0, 1'b0, 0, "L0 wr0");
        prev_hs = last_hs;
        txn(0, 1'b0, 32'd0, 32'd0, 32'h11, 1'b0, 0, "L0 rd0");
        chk("b2b accept gap", 32'(last_acc - prev_hs), 32'd1);

        txn(0, 1'b1, 32'd1024, 32'h5A, 32'd0, 1'b1, 0, "oor wr1024");
        txn(0, 1'b0, 32'd0, 32'd0, 32'h11, 1'b0, 0, "rd0 after oor");
        txn(0, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 0, "oor rdffff");
        txn(0, 1'b1, 32'd1023, 32'h0000ABCD, 32'd0, 1'b0, 0, "wr1023");
        txn(0, 1'b0, 32'd1023, 32'd0, 32'h0000ABCD, 1'b0, 0, "rd1023");

        txn(1, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 6, "bp rd5");
        txn(1, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 0, "rd5 after bp");

        // Abort a write while it is still waiting for its commit edge.
        txn(1, 1'b1, 32'd7, 32'h70, 32'd0, 1'b0, 0, "preload7");
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 32'd7;
        req_wdata[1]  = 32'h77;
        @(negedge clk);
        chk("abort ready before accept", 32'(req_ready[1]), 32'd1);
        pulse_seen = 1'b0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        chk("abort accepted busy", 32'(busy[1]), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_idle_zero(1, "abort rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no resp pulse", 32'(pulse_seen), 32'd0);
        txn(1, 1'b0, 32'd7, 32'd0, 32'h70, 1'b0, 0, "rd7 after abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
